// File: rtl/rg_sample_reader.sv
// Ring-generator TRNG reader: warm-up, decimation, repetition/stuck-at screening, FWFT output FIFO.
// A passing sample shows on o_data the cycle after its sample edge; a full FIFO with no pop drops it (o_drop).
module rg_sample_reader #(
  parameter int DECIM      = 32,
  parameter int WARMUP     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int RCT_LIMIT  = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  input  logic [31:0]                 i_rg_data,
  output logic [31:0]                 o_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_fault,
  output logic                        o_drop,
  input  logic                        i_clr_fault
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(WARMUP + 1);
  localparam int DW = $clog2(DECIM + 1);
  localparam int RW = $clog2(RCT_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_FAULT} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [WW-1:0]   r_wcnt;
  logic [DW-1:0]   r_dcnt;
  logic [31:0]     r_prev;
  logic            r_prev_valid;
  logic [RW-1:0]   r_rep_cnt;
  logic [31:0]     r_mem [FIFO_DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic            r_drop;

  logic            w_sample;
  logic            w_fail;
  logic            w_rct_trip;
  logic            w_pop;
  logic            w_push;
  logic            w_full;
  logic            w_flush;
  logic [AW:0]     w_level;

  assign w_level    = r_wr_ptr - r_rd_ptr;
  // Depth is a power of two, so the extra pointer bit of the level is the full flag.
  assign w_full     = w_level[AW];
  assign w_sample   = (r_state == S_RUN) && i_en && (r_dcnt == DW'(DECIM - 1));
  assign w_fail     = (i_rg_data == 32'h0) || (r_prev_valid && (i_rg_data == r_prev));
  assign w_rct_trip = w_sample && w_fail && (r_rep_cnt == RW'(RCT_LIMIT - 1));
  assign w_pop      = o_valid && i_ready;
  assign w_push     = w_sample && !w_fail && (!w_full || w_pop);
  assign w_flush    = (w_next == S_FAULT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_en) w_next = S_WARMUP;
      S_WARMUP: if (!i_en) w_next = S_IDLE;
                else if (r_wcnt == WW'(WARMUP - 1)) w_next = S_RUN;
      S_RUN:    if (!i_en) w_next = S_IDLE;
                else if (w_rct_trip) w_next = S_FAULT;
      S_FAULT:  if (i_clr_fault) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_fault = (r_state == S_FAULT);
    o_valid = (w_level != '0);
    o_level = w_level;
    o_data  = r_mem[r_rd_ptr[AW-1:0]];
    o_drop  = r_drop;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wcnt <= '0;
      r_dcnt <= '0;
    end else begin
      if (r_state == S_WARMUP) r_wcnt <= r_wcnt + WW'(1);
      else                     r_wcnt <= '0;
      if (r_state != S_RUN || r_dcnt == DW'(DECIM - 1)) r_dcnt <= '0;
      else                                               r_dcnt <= r_dcnt + DW'(1);
    end
  end

  // Health history restarts whenever the sampler goes back to IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_rep_cnt    <= '0;
    end else if (w_next == S_IDLE) begin
      r_prev_valid <= 1'b0;
      r_rep_cnt    <= '0;
    end else if (w_sample) begin
      r_prev       <= i_rg_data;
      r_prev_valid <= 1'b1;
      r_rep_cnt    <= w_fail ? r_rep_cnt + RW'(1) : '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_rg_data;
        r_wr_ptr                <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                               r_drop <= 1'b0;
    else if (i_clr_fault)                    r_drop <= 1'b0;
    else if (w_sample && !w_fail && !w_push) r_drop <= 1'b1;
  end

endmodule

// File: tb/tb_rg_sample_reader.sv
// Bench for rg_sample_reader: directed scenarios plus randomized traffic against a queue-based model.
module tb_rg_sample_reader;

  localparam int DECIM  = 4;
  localparam int WARMUP = 8;
  localparam int DEPTH  = 4;
  localparam int RCT    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        ready = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] rg = 32'h0;
  logic [31:0] o_data;
  logic        o_valid;
  logic [2:0]  o_level;
  logic        o_fault;
  logic        o_drop;

  int n_assert = 0;
  int n_fail = 0;

  // Reference model: sample edges are e0 + WARMUP + k*DECIM (k>=1), e0 being the edge enable is seen.
  int          m_n = 0;
  int          m_e0 = 0;
  bit          m_active = 0;
  bit          m_fault = 0;
  bit          m_drop = 0;
  bit          m_pv = 0;
  int          m_rep = 0;
  logic [31:0] m_prev = 32'h0;
  logic [31:0] mq[$];

  rg_sample_reader #(.DECIM(DECIM), .WARMUP(WARMUP), .FIFO_DEPTH(DEPTH), .RCT_LIMIT(RCT)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_rg_data(rg),
    .o_data(o_data), .o_valid(o_valid), .i_ready(ready), .o_level(o_level),
    .o_fault(o_fault), .o_drop(o_drop), .i_clr_fault(clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit next_is_sample();
    return m_active && !m_fault && en && (m_n - m_e0 > WARMUP) && ((m_n - m_e0 - WARMUP) % DECIM == 0);
  endfunction

  task automatic model_reset();
    m_active = 0; m_fault = 0; m_drop = 0; m_pv = 0; m_rep = 0; m_prev = 32'h0;
    mq.delete();
  endtask

  task automatic model_edge();
    bit pop;
    bit smp;
    bit fail;
    pop = (mq.size() != 0) && ready;
    smp = next_is_sample();
    if (m_fault) begin
      if (clr) begin m_fault = 0; m_active = 0; m_rep = 0; m_pv = 0; end
    end else begin
      if (pop) void'(mq.pop_front());
      if (!m_active) begin
        if (en) begin m_active = 1; m_e0 = m_n; end
      end else if (!en) begin
        m_active = 0; m_pv = 0; m_rep = 0;
      end else if (smp) begin
        fail = (rg == 32'h0) || (m_pv && rg == m_prev);
        m_prev = rg;
        m_pv = 1;
        if (fail) begin
          m_rep++;
          if (m_rep == RCT) begin m_fault = 1; mq.delete(); end
        end else begin
          m_rep = 0;
          if (mq.size() < DEPTH) mq.push_back(rg);
          else m_drop = 1;
        end
      end
    end
    if (clr) m_drop = 0;
    m_n++;
  endtask

  task automatic compare_all();
    chk("valid", 32'(o_valid), 32'(mq.size() != 0));
    chk("level", 32'(o_level), 32'(mq.size()));
    chk("fault", 32'(o_fault), 32'(m_fault));
    chk("drop", 32'(o_drop), 32'(m_drop));
    if (mq.size() != 0) chk("data", o_data, mq[0]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    compare_all();
    if (rst) chk("rst_data", o_data, 32'h0);
  endtask

  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("async_rst_data", o_data, 32'h0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  int  cnt;
  int  nsamp;
  bit  ok;
  int  r;

  initial begin
    // Reset held with enable high and data moving.
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin rg = $urandom; tick(); end
    rst = 1'b0; rg = 32'h1; ready = 1'b1;
    tick();
    cnt = 0; ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin rg = rg + 1; tick(); cnt++; if (o_valid) ok = 1; end
    chk("first_sample_lat", cnt, WARMUP + DECIM);

    // Incrementing stream, always ready.
    for (int i = 0; i < 40; i++) begin rg = rg + 1; tick(); chk("lvl_le1", 32'(o_level <= 1), 1); end

    // Fill with ready low, then overflow.
    ready = 1'b0; ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin rg = rg + 1; tick(); if (m_drop) ok = 1; end
    chk("fill_drop_seen", 32'(o_drop), 1);
    chk("fill_level", 32'(o_level), 4);
    ok = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      rg = rg + 1;
      if (next_is_sample()) begin ready = 1'b1; ok = 1; end
      tick();
    end
    chk("full_push_pop_found", 32'(ok), 1);
    chk("full_push_pop_level", 32'(o_level), 4);
    for (int i = 0; i < 24; i++) begin rg = rg + 1; tick(); end
    clr = 1'b1; tick(); clr = 1'b0;
    chk("drop_cleared", 32'(o_drop), 0);

    // Stuck data: one pass, then repeated fails into FAULT with a flush.
    ready = 1'b0; rg = 32'hDEADBEEF; nsamp = 0;
    for (int i = 0; i < 60 && !m_fault; i++) begin if (next_is_sample()) nsamp++; tick(); end
    chk("dead_samples", nsamp, 4);
    chk("dead_fault", 32'(o_fault), 1);
    chk("dead_flush_level", 32'(o_level), 0);
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin rg = $urandom; tick(); end
    clr = 1'b1; tick(); clr = 1'b0;
    chk("dead_clr_fault", 32'(o_fault), 0);

    // All-zero data from a fresh reset.
    async_reset();
    rg = 32'h0; en = 1'b1;
    tick();
    cnt = 0;
    for (int i = 0; i < 60 && !o_fault; i++) begin tick(); cnt++; end
    chk("zero_fault_lat", cnt, WARMUP + RCT * DECIM);
    clr = 1'b1; en = 1'b0; tick(); clr = 1'b0; tick();

    // Enable dropped in RUN with two words buffered.
    en = 1'b1; ready = 1'b0; rg = 32'h100;
    for (int i = 0; i < 80 && mq.size() != 2; i++) begin rg = rg + 1; tick(); end
    chk("two_buffered", 32'(o_level), 2);
    en = 1'b0; rg = rg + 1; tick();
    ready = 1'b1; cnt = 0;
    for (int i = 0; i < 20; i++) begin if (o_valid) cnt++; rg = rg + 1; tick(); end
    chk("idle_drain_cnt", cnt, 2);
    en = 1'b1; tick();
    cnt = 0; ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin rg = rg + 1; tick(); cnt++; if (o_valid) ok = 1; end
    chk("reenable_lat", cnt, WARMUP + DECIM);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      en = en ? ($urandom_range(0, 199) != 0) : ($urandom_range(0, 7) == 0);
      ready = ($urandom_range(0, 9) < 4);
      clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 7);
        rg = (r == 0) ? 32'h0 : $urandom;
      end
      if (i == 1200) async_reset();
      else tick();
    end
    clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
